// File: rtl/sync_frame_tx.sv
// sync_frame_tx: bit-serial frame transmitter. Each accepted payload word is
// sent as a SYNC_W-bit sync header followed by DATA_W payload bits, MSB first,
// one bit per clock, then a single idle gap bit. Words arrive over a
// valid/ready handshake that is open in IDLE and in the gap cycle.
module sync_frame_tx #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       SYNC_W = 5,
  parameter logic [SYNC_W-1:0] SYNC   = 5'b11011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              n,
  output logic              busy,
  output logic              tx_done
);

  // One counter serves both phases, so it is sized for the longer of the two.
  localparam int unsigned CNT_MAX = (SYNC_W > DATA_W) ? SYNC_W - 1 : DATA_W - 1;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                n_q, n_d;
  logic                hs;
  logic [SYNC_W-1:0]   sync_sel;

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk IDLE -> SYNC -> DATA -> GAP, re-entering SYNC
  // directly from GAP when a new word is handed over.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = hs ? ST_SYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state; the handshake is only open in
  // IDLE and GAP, so in_valid anywhere else is ignored.
  always_comb begin
    in_ready = (state_q == ST_IDLE) || (state_q == ST_GAP);
    busy     = (state_q == ST_SYNC) || (state_q == ST_DATA);
    tx_done  = (state_q == ST_GAP);
    hs       = in_valid && in_ready;
    n        = n_q;
  end

  // Datapath next values: bit counter and payload shift register.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          shift_d = in_data;
          cnt_d   = '0;
        end
      end
      ST_SYNC: begin
        cnt_d = (cnt_q == SYNC_LAST) ? '0 : cnt_q + 1'b1;
      end
      ST_DATA: begin
        shift_d = shift_q << 1;
        cnt_d   = (cnt_q == DATA_LAST) ? '0 : cnt_q + 1'b1;
      end
      ST_GAP: begin
        cnt_d = '0;
        if (hs) shift_d = in_data;
      end
      default: begin
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // Serial line next value. The line is a flop, so the bit is chosen from the
  // next state/counter/shift values; the registered n then lines up with the
  // state it belongs to, one cycle after the handshake edge.
  always_comb begin
    sync_sel = SYNC << cnt_d;
    case (state_d)
      ST_SYNC: n_d = sync_sel[SYNC_W-1];
      ST_DATA: n_d = shift_d[DATA_W-1];
      default: n_d = 1'b0;
    endcase
  end

  // Datapath registers and the serial output flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      n_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: directed bench for sync_frame_tx with a scoreboard.
// The driver pushes one expected entry per frame cycle at each handshake; the
// monitor pops and compares whenever the DUT is busy or pulsing tx_done, and
// checks the line is quiet otherwise. A behavioural 11011 Mealy detector on n
// stands in for the far-end receiver.
module tb_sync_frame_tx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = '0;
  logic       in_ready;
  logic       n;
  logic       busy;
  logic       tx_done;

  sync_frame_tx #(
    .DATA_W (8),
    .SYNC_W (5),
    .SYNC   (5'b11011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .n        (n),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic n;
    logic busy;
    logic done;
    logic det;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] hist = '0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each presented output cycle against the scoreboard head.
  always @(negedge clk) begin
    logic det;
    exp_t e;
    if (rst) begin
      det = (hist == 4'b1101) && n;
      if (busy || tx_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_busy", busy, 1'b0);
          chk("unexpected_tx_done", tx_done, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk_int("frame_cycle", cyc, e.cyc);
          chk("n", n, e.n);
          chk("busy", busy, e.busy);
          chk("tx_done", tx_done, e.done);
          chk("in_ready", in_ready, e.done);
          chk("detector", det, e.det);
        end
      end else begin
        chk("idle_n", n, 1'b0);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_detector", det, 1'b0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          chk("missing_busy", busy, 1'b1);
          void'(sbq.pop_front());
        end
      end
      hist = {hist[2:0], n};
    end else begin
      hist = '0;
    end
  end

  // Queue the 14 expected cycles (13 bits + gap) of a frame handshaken at edge k.
  task automatic push_frame(input int k, input logic [13:0] en, input logic [13:0] ed);
    logic [13:0] sn;
    logic [13:0] sd;
    sn = en;
    sd = ed;
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      e.cyc  = k + i;
      e.n    = sn[13];
      e.busy = (i < 13);
      e.done = (i == 13);
      e.det  = sd[13];
      sbq.push_back(e);
      sn = sn << 1;
      sd = sd << 1;
    end
  endtask

  // Present a word and wait (bounded) until in_ready; k is the handshake edge.
  task automatic offer(input logic [7:0] d, output int k);
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 40 && !in_ready; t++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      chk("handshake_timeout", in_ready, 1'b1);
      k = -1;
    end else begin
      k = cyc + 1;
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    for (int t = 0; t < 60 && cyc < target; t++) begin
      @(negedge clk);
      #1;
    end
    chk_int("wait_cycle_reached", cyc, target);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sbq.size() != 0; t++) @(negedge clk);
    chk_int("scoreboard_drained", sbq.size(), 0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int k2;

    // Reset state
    #2;
    chk("reset_n", n, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_done", tx_done, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Single frame A5
    offer(8'hA5, k);
    push_frame(k, 14'b11011_10100101_0, 14'b00001_00000000_0);
    drop_valid();
    drain();

    // Back-to-back FF then 00 with in_valid held high
    offer(8'hFF, k);
    push_frame(k, 14'b11011_11111111_0, 14'b00001_00000000_0);
    @(negedge clk);
    #1;
    in_data = 8'h00;
    offer(8'h00, k2);
    chk_int("back_to_back_edge", k2, k + 14);
    push_frame(k2, 14'b11011_00000000_0, 14'b01001_00000000_0);
    drop_valid();
    drain();

    // Ignored input during DATA phase
    offer(8'hA5, k);
    push_frame(k, 14'b11011_10100101_0, 14'b00001_00000000_0);
    drop_valid();
    wait_cycle(k + 7);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    chk("ready_low_in_data", in_ready, 1'b0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    drain();
    repeat (16) @(negedge clk);
    #1;

    // Reset during the 3rd payload bit, then an intact 81 frame
    offer(8'hA5, k);
    push_frame(k, 14'b11011_10100101_0, 14'b00001_00000000_0);
    drop_valid();
    wait_cycle(k + 7);
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_n", n, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_tx_done", tx_done, 1'b0);
    chk("midreset_in_ready", in_ready, 1'b1);
    sbq.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;
    offer(8'h81, k);
    push_frame(k, 14'b11011_10000001_0, 14'b00001_00000000_0);
    drop_valid();
    drain();

    // Loopback: 00 gives one detector pulse, D8 gives two (no stuffing)
    offer(8'h00, k);
    push_frame(k, 14'b11011_00000000_0, 14'b00001_00000000_0);
    drop_valid();
    drain();
    offer(8'hD8, k);
    push_frame(k, 14'b11011_11011000_0, 14'b00001_00001000_0);
    drop_valid();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
